conv3x3_seq: RTL and testbench



---
 rtl/conv_pkg.sv | 19 +
 rtl/mac3_row.sv | 37 +++
 rtl/conv3x3_seq.sv | 202 ++++++++++++++++++++
 tb/tb_conv3x3_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer and its row datapath.
package conv_pkg;

  localparam int DW         = 10;
  localparam int ACC_W      = 24;
  localparam int FRAC       = 9;
  localparam int SAT_MAX    = 511;
  localparam int SAT_MIN    = -512;
  localparam int ROUND_HALF = 1 << (FRAC - 1);
  localparam int N_TAPS     = 9;

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    HOLD = 2'd3
  } conv_state_t;

endpackage

// File: rtl/mac3_row.sv
// Combinational 3-tap signed dot product; each product is sign-extended to ACC_W before summing.
module mac3_row #(
  parameter int DW    = conv_pkg::DW,
  parameter int ACC_W = conv_pkg::ACC_W
) (
  input  logic signed [DW-1:0]    x0,
  input  logic signed [DW-1:0]    x1,
  input  logic signed [DW-1:0]    x2,
  input  logic signed [DW-1:0]    w0,
  input  logic signed [DW-1:0]    w1,
  input  logic signed [DW-1:0]    w2,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [DW-1:0]    x_arr [3];
  logic signed [DW-1:0]    w_arr [3];
  logic signed [2*DW-1:0]  prod  [3];
  logic signed [ACC_W-1:0] prod_ext [3];

  assign x_arr[0] = x0;
  assign x_arr[1] = x1;
  assign x_arr[2] = x2;
  assign w_arr[0] = w0;
  assign w_arr[1] = w1;
  assign w_arr[2] = w2;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      assign prod[gi]     = x_arr[gi] * w_arr[gi];
      assign prod_ext[gi] = {{(ACC_W-2*DW){prod[gi][2*DW-1]}}, prod[gi]};
    end
  endgenerate

  assign sum = prod_ext[0] + prod_ext[1] + prod_ext[2];

endmodule

// File: rtl/conv3x3_seq.sv
// 3x3 convolution sequencer: three row passes through one shared MAC, then Q1.9 clip/wrap to a valid/ready output.
// Define CONV_ROUND_EN to round half up before clip/wrap; otherwise the result is truncated.
module conv3x3_seq
  import conv_pkg::*;
#(
  parameter int DW    = conv_pkg::DW,
  parameter int ACC_W = conv_pkg::ACC_W,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clip,
  input  logic                    flush,
  input  logic                    w_wr,
  input  logic [3:0]              w_addr,
  input  logic signed [DW-1:0]    w_data,
  output logic                    w_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    x0,
  input  logic signed [DW-1:0]    x1,
  input  logic signed [DW-1:0]    x2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_data,
  output logic                    busy,
  output logic [CNT_W-1:0]        win_count
);

  localparam logic signed [ACC_W-1:0] SAT_MAX_EXT = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_MIN_EXT = ACC_W'(SAT_MIN);

  conv_state_t              state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     clip_q, clip_d;
  logic signed [DW-1:0]     out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     w_err_q, w_err_d;
  logic [CNT_W-1:0]         win_count_q, win_count_d;
  logic signed [DW-1:0]     w_q [N_TAPS];
  logic signed [DW-1:0]     w_d [N_TAPS];

  logic [3:0]               row_base;
  logic signed [DW-1:0]     w_row [3];
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  pre_shift;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DW-1:0]     result;
  logic                     beat;
  logic                     w_addr_ok;

  // in_ready is a function of state and w_wr only, never of out_ready.
  assign in_ready  = (state_q != HOLD) && !((state_q == ROW0) && w_wr);
  assign beat      = in_valid && in_ready;
  assign busy      = (state_q != ROW0);
  assign w_addr_ok = (w_addr <= 4'd8);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign w_err     = w_err_q;
  assign win_count = win_count_q;

  always_comb begin
    case (state_q)
      ROW1:    row_base = 4'd3;
      ROW2:    row_base = 4'd6;
      default: row_base = 4'd0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_wsel
      assign w_row[gi] = w_q[row_base + 4'(gi)];
    end
  endgenerate

  mac3_row #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .x0  (x0),
    .x1  (x1),
    .x2  (x2),
    .w0  (w_row[0]),
    .w1  (w_row[1]),
    .w2  (w_row[2]),
    .sum (mac_sum)
  );

  assign acc_base = (state_q == ROW0) ? '0 : acc_q;
  assign acc_sum  = acc_base + mac_sum;

`ifdef CONV_ROUND_EN
  assign pre_shift = acc_sum + ACC_W'(ROUND_HALF);
`else
  assign pre_shift = acc_sum;
`endif

  assign shifted = pre_shift >>> FRAC;

  // Clip mode uses the mode latched on the window's first beat, not the live input.
  always_comb begin
    result = shifted[DW-1:0];
    if (clip_q) begin
      if (shifted > SAT_MAX_EXT) begin
        result = SAT_MAX_EXT[DW-1:0];
      end else if (shifted < SAT_MIN_EXT) begin
        result = SAT_MIN_EXT[DW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    clip_d      = clip_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    win_count_d = win_count_q;
    w_err_d     = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      w_d[i] = w_q[i];
    end

    if (flush) begin
      state_d     = ROW0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      w_err_d     = w_wr && w_addr_ok;
    end else begin
      if (w_wr && w_addr_ok) begin
        if (state_q == ROW0) begin
          w_d[w_addr] = w_data;
        end else begin
          w_err_d = 1'b1;
        end
      end

      case (state_q)
        ROW0: begin
          if (beat) begin
            acc_d   = acc_sum;
            clip_d  = clip;
            state_d = ROW1;
          end
        end
        ROW1: begin
          if (beat) begin
            acc_d   = acc_sum;
            state_d = ROW2;
          end
        end
        ROW2: begin
          if (beat) begin
            acc_d       = acc_sum;
            out_data_d  = result;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            win_count_d = win_count_q + 1'b1;
            state_d     = ROW0;
          end
        end
        default: state_d = ROW0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ROW0;
      acc_q       <= '0;
      clip_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      w_err_q     <= 1'b0;
      win_count_q <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      clip_q      <= clip_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      w_err_q     <= w_err_d;
      win_count_q <= win_count_d;
      for (int i = 0; i < N_TAPS; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_seq.sv
// Directed bench for conv3x3_seq: hand-computed windows, backpressure, write rules and flush.
module tb_conv3x3_seq;

  logic              clk;
  logic              reset;
  logic              clip;
  logic              flush;
  logic              w_wr;
  logic [3:0]        w_addr;
  logic signed [9:0] w_data;
  logic              w_err;
  logic              in_valid;
  logic              in_ready;
  logic signed [9:0] x0, x1, x2;
  logic              out_valid;
  logic              out_ready;
  logic signed [9:0] out_data;
  logic              busy;
  logic [15:0]       win_count;

  int checks = 0;
  int errors = 0;
  int exp_wins = 0;
  int px[9];
  int wv[9];
  int res;

  conv3x3_seq dut (
    .clk       (clk),
    .reset     (reset),
    .clip      (clip),
    .flush     (flush),
    .w_wr      (w_wr),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_err     (w_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .win_count (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input int data);
    w_wr   = 1'b1;
    w_addr = 4'(addr);
    w_data = 10'(data);
    tick();
    w_wr   = 1'b0;
  endtask

  task automatic load_weights(input int ws[9]);
    for (int i = 0; i < 9; i++) begin
      write_w(i, ws[i]);
    end
  endtask

  task automatic send_beat(input int a, input int b, input int c);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    x0 = 10'(a);
    x1 = 10'(b);
    x2 = 10'(c);
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic run_window(input bit c, input int xs[9]);
    clip = c;
    send_beat(xs[0], xs[1], xs[2]);
    send_beat(xs[3], xs[4], xs[5]);
    send_beat(xs[6], xs[7], xs[8]);
    check("valid_rise", int'(out_valid), 1);
  endtask

  task automatic get_result(input string tag, input int exp);
    bit done;
    int d;
    done = 1'b0;
    d = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (out_valid) begin
        done = 1'b1;
        d = int'(out_data);
      end
      tick();
    end
    out_ready = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      exp_wins++;
      $display("window %0d (%s): out_data=%0d expected=%0d", exp_wins, tag, d, exp);
      check(tag, d, exp);
      check({tag, "_wincnt"}, int'(win_count), exp_wins);
      check({tag, "_valid_fall"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    reset = 1'b1; clip = 1'b0; flush = 1'b0; w_wr = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; x0 = '0; x1 = '0; x2 = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_w_err",     int'(w_err), 0);
    check("rst_win_count", int'(win_count), 0);
    check("rst_in_ready",  int'(in_ready), 1);
    check("rst_busy",      int'(busy), 0);
    tick();

    // Identity: only w[4] = 256, centre pixel 100 -> 25600 >>> 9 = 50
    write_w(4, 256);
    px = '{0, 0, 0, 0, 100, 0, 0, 0, 0};
    run_window(1'b1, px);
    check("hold_busy", int'(busy), 1);
    check("hold_in_ready", int'(in_ready), 0);
    get_result("identity", 50);
    check("idle_busy", int'(busy), 0);

    // All 256: 9 * 65536 >>> 9 = 1152 -> clip 511, wrap 128
    wv = '{256, 256, 256, 256, 256, 256, 256, 256, 256};
    load_weights(wv);
    px = '{256, 256, 256, 256, 256, 256, 256, 256, 256};
    run_window(1'b1, px);
    get_result("sat_pos", 511);
    run_window(1'b0, px);

    // Backpressure for 5 cycles, with a dropped HOLD write and an ignored addr-9 write
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      w_wr   = (c == 1) || (c == 3);
      w_addr = (c == 1) ? 4'd0 : 4'd9;
      w_data = 10'sd5;
      #1;
      check("bp_data", int'(out_data), 128);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_valid", int'(out_valid), 1);
      tick();
      w_wr = 1'b0;
      if (c == 1) check("w_err_hold", int'(w_err), 1);
      if (c == 2) check("w_err_pulse_end", int'(w_err), 0);
      if (c == 3) check("w_err_addr9", int'(w_err), 0);
    end
    get_result("wrap", 128);
    run_window(1'b0, px);
    get_result("weight_kept", 128);

    // Write together with a beat in ROW0: write lands, beat waits one cycle.
    // Row0 = -65536+2*65536, rows1-2 = 6*65536 -> 458752 >>> 9 = 896 -> wrap -128
    in_valid = 1'b1; x0 = 10'sd256; x1 = 10'sd256; x2 = 10'sd256; clip = 1'b0;
    w_wr = 1'b1; w_addr = 4'd0; w_data = -10'sd256;
    #1;
    check("wr_beat_block", int'(in_ready), 0);
    tick();
    w_wr = 1'b0;
    #1;
    check("wr_beat_busy0", int'(busy), 0);
    check("wr_beat_ready", int'(in_ready), 1);
    check("wr_beat_no_err", int'(w_err), 0);
    tick();
    in_valid = 1'b0;
    check("wr_beat_accept", int'(busy), 1);
    send_beat(256, 256, 256);
    send_beat(256, 256, 256);
    check("valid_rise_wr", int'(out_valid), 1);
    get_result("new_weight", -128);

    // Flush after two beats of 511; the write in the flush cycle is dropped
    send_beat(511, 511, 511);
    send_beat(511, 511, 511);
    check("pre_flush_busy", int'(busy), 1);
    flush = 1'b1; w_wr = 1'b1; w_addr = 4'd0; w_data = 10'sd7;
    tick();
    flush = 1'b0; w_wr = 1'b0;
    check("flush_busy", int'(busy), 0);
    check("flush_valid", int'(out_valid), 0);
    check("flush_w_err", int'(w_err), 1);
    check("flush_wincnt", int'(win_count), exp_wins);
    run_window(1'b0, px);
    get_result("post_flush", -128);

    // Negative saturation: 9 * (511 * -512) >>> 9 = -4599 -> -512
    wv = '{-512, -512, -512, -512, -512, -512, -512, -512, -512};
    load_weights(wv);
    px = '{511, 511, 511, 511, 511, 511, 511, 511, 511};
    run_window(1'b1, px);
    get_result("sat_neg", -512);

    // Rounding: 1 * 256 = 256 -> 0 truncated, 1 rounded
    wv = '{256, 0, 0, 0, 0, 0, 0, 0, 0};
    load_weights(wv);
    px = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_window(1'b1, px);
`ifdef CONV_ROUND_EN
    get_result("round", 1);
`else
    get_result("round", 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
